// File: rtl/rom_access_ctrl.sv
// rom_access_ctrl: request-side sequencer for the 512x32 expansion ROM.
// Turns word read/write requests into single-cycle ROM accesses, merging
// partial byte-enable writes by read-modify-write (the ROM has one wren).
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_write, i_req_addr, i_req_be, i_req_wdata
//                         request handshake and payload
//   o_rsp_valid, o_rsp_data, o_rsp_err
//                         one-cycle response pulse, held read data, drop flag
//   o_rom_enable, o_rom_wren, o_rom_address, o_rom_dinp
//                         registered ROM controls
//   i_rom_dout            ROM read data, one cycle after a read enable
module rom_access_ctrl #(
    parameter int unsigned AW       = 9,
    parameter int unsigned DW       = 32,
    parameter bit          WRITABLE = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_write,
    input  logic [AW-1:0]   i_req_addr,
    input  logic [DW/8-1:0] i_req_be,
    input  logic [DW-1:0]   i_req_wdata,
    output logic            o_rsp_valid,
    output logic [DW-1:0]   o_rsp_data,
    output logic            o_rsp_err,
    output logic            o_rom_enable,
    output logic            o_rom_wren,
    output logic [AW-1:0]   o_rom_address,
    output logic [DW-1:0]   o_rom_dinp,
    input  logic [DW-1:0]   i_rom_dout
);

    localparam int unsigned BEW = DW / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_CAP,
        S_RMW_RD,
        S_RMW_MERGE,
        S_WR_COMMIT,
        S_ACK
    } state_t;

    state_t          r_state;
    logic            r_rom_enable;
    logic            r_rom_wren;
    logic [AW-1:0]   r_rom_address;
    logic [DW-1:0]   r_rom_dinp;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_err;
    logic [BEW-1:0]  r_be;
    logic [DW-1:0]   r_wdata;

    state_t          w_state_nxt;
    logic            w_rom_enable_nxt;
    logic            w_rom_wren_nxt;
    logic [AW-1:0]   w_rom_address_nxt;
    logic [DW-1:0]   w_rom_dinp_nxt;
    logic [DW-1:0]   w_rsp_data_nxt;
    logic            w_rsp_err_nxt;
    logic [BEW-1:0]  w_be_nxt;
    logic [DW-1:0]   w_wdata_nxt;
    logic [DW-1:0]   w_merged;
    logic            w_idle;
    logic            w_accept;

    // The ACK cycle doubles as an idle cycle so a new request can be
    // taken while the previous response is on the bus.
    assign w_idle      = (r_state == S_IDLE) || (r_state == S_ACK);
    assign o_req_ready = w_idle && !i_rst;
    assign w_accept    = i_req_valid && o_req_ready;

    assign o_rsp_valid   = (r_state == S_ACK);
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_err     = r_rsp_err;
    assign o_rom_enable  = r_rom_enable;
    assign o_rom_wren    = r_rom_wren;
    assign o_rom_address = r_rom_address;
    assign o_rom_dinp    = r_rom_dinp;

    // Enabled lanes come from the request, the rest from the ROM word
    // read back in the previous cycle.
    always_comb begin
        w_merged = i_rom_dout;
        for (int i = 0; i < int'(BEW); i++) begin
            if (r_be[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rom_enable_nxt  = 1'b0;
        w_rom_wren_nxt    = 1'b0;
        w_rom_address_nxt = r_rom_address;
        w_rom_dinp_nxt    = r_rom_dinp;
        w_rsp_data_nxt    = r_rsp_data;
        w_rsp_err_nxt     = 1'b0;
        w_be_nxt          = r_be;
        w_wdata_nxt       = r_wdata;

        unique case (r_state)
            S_IDLE, S_ACK: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    w_be_nxt    = i_req_be;
                    w_wdata_nxt = i_req_wdata;
                    if (!i_req_write) begin
                        w_state_nxt       = S_RD_ISSUE;
                        w_rom_enable_nxt  = 1'b1;
                        w_rom_address_nxt = i_req_addr;
                    end else if (!WRITABLE || (i_req_be == '0)) begin
                        // Nothing reaches the ROM; acknowledge at once.
                        w_state_nxt   = S_ACK;
                        w_rsp_err_nxt = !WRITABLE;
                    end else if (&i_req_be) begin
                        w_state_nxt       = S_WR_COMMIT;
                        w_rom_enable_nxt  = 1'b1;
                        w_rom_wren_nxt    = 1'b1;
                        w_rom_address_nxt = i_req_addr;
                        w_rom_dinp_nxt    = i_req_wdata;
                    end else begin
                        w_state_nxt       = S_RMW_RD;
                        w_rom_enable_nxt  = 1'b1;
                        w_rom_address_nxt = i_req_addr;
                    end
                end
            end
            S_RD_ISSUE: begin
                w_state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_rsp_data_nxt = i_rom_dout;
                w_state_nxt    = S_ACK;
            end
            S_RMW_RD: begin
                w_state_nxt = S_RMW_MERGE;
            end
            S_RMW_MERGE: begin
                // Address is still held from the read half of the RMW.
                w_rom_enable_nxt = 1'b1;
                w_rom_wren_nxt   = 1'b1;
                w_rom_dinp_nxt   = w_merged;
                w_state_nxt      = S_WR_COMMIT;
            end
            S_WR_COMMIT: begin
                w_state_nxt = S_ACK;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_rom_enable  <= 1'b0;
            r_rom_wren    <= 1'b0;
            r_rom_address <= '0;
            r_rom_dinp    <= '0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_be          <= '0;
            r_wdata       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rom_enable  <= w_rom_enable_nxt;
            r_rom_wren    <= w_rom_wren_nxt;
            r_rom_address <= w_rom_address_nxt;
            r_rom_dinp    <= w_rom_dinp_nxt;
            r_rsp_data    <= w_rsp_data_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_be          <= w_be_nxt;
            r_wdata       <= w_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_rom_access_ctrl.sv
// tb_rom_access_ctrl: bench for rom_access_ctrl with a behavioural ROM,
// a word-level shadow memory and a read-only second instance.
module tb_rom_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rom_enable;
    logic        rom_wren;
    logic [8:0]  rom_address;
    logic [31:0] rom_dinp;
    logic [31:0] rom_dout;

    logic        ro_valid;
    logic        ro_ready;
    logic        ro_write;
    logic [8:0]  ro_addr;
    logic [3:0]  ro_be;
    logic [31:0] ro_wdata;
    logic        ro_rsp_valid;
    logic [31:0] ro_rsp_data;
    logic        ro_rsp_err;
    logic        ro_en;
    logic        ro_wren;
    logic [8:0]  ro_address;
    logic [31:0] ro_dinp;
    logic [31:0] ro_dout;

    logic        pl_we;
    logic [8:0]  pl_addr;
    logic [31:0] pl_data;

    logic [31:0] rom     [512];
    logic [31:0] ref_mem [512];
    logic [31:0] last_rd;

    int n_chk;
    int n_pass;
    int bad_wren;
    int bad_err;

    typedef struct {
        logic        wr;
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        int          nen;
        int          wrk;
        logic [31:0] wdin;
    } vec_t;

    vec_t tbl [7];

    rom_access_ctrl #(.AW(9), .DW(32), .WRITABLE(1'b1)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_addr(req_addr),
        .i_req_be(req_be), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_rsp_err(rsp_err),
        .o_rom_enable(rom_enable), .o_rom_wren(rom_wren),
        .o_rom_address(rom_address), .o_rom_dinp(rom_dinp),
        .i_rom_dout(rom_dout)
    );

    rom_access_ctrl #(.AW(9), .DW(32), .WRITABLE(1'b0)) u_ro (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(ro_valid), .o_req_ready(ro_ready),
        .i_req_write(ro_write), .i_req_addr(ro_addr),
        .i_req_be(ro_be), .i_req_wdata(ro_wdata),
        .o_rsp_valid(ro_rsp_valid), .o_rsp_data(ro_rsp_data),
        .o_rsp_err(ro_rsp_err),
        .o_rom_enable(ro_en), .o_rom_wren(ro_wren),
        .o_rom_address(ro_address), .o_rom_dinp(ro_dinp),
        .i_rom_dout(ro_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) begin
            rom[pl_addr] <= pl_data;
        end else if (rom_enable) begin
            if (rom_wren) rom[rom_address] <= rom_dinp;
            else rom_dout <= rom[rom_address];
        end
    end

    always @(negedge clk) begin
        if (rom_wren && !rom_enable) bad_wren++;
        if ((rsp_err && !rsp_valid) || (ro_rsp_err && !ro_rsp_valid))
            bad_err++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_word(input int i);
        logic [8:0] a;
        a = i[8:0];
        if (i == 0) return 32'h55AA_0001;
        if (i == 16) return 32'h1122_3344;
        return {7'h0, a, 16'hC0DE};
    endfunction

    function automatic int exp_lat(input logic wr, input logic [3:0] be);
        if (!wr) return 3;
        if (be == 4'h0) return 1;
        if (be == 4'hF) return 2;
        return 4;
    endfunction

    function automatic int exp_nen(input logic wr, input logic [3:0] be);
        if (!wr) return 1;
        if (be == 4'h0) return 0;
        if (be == 4'hF) return 1;
        return 2;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic ref_apply(input logic wr, input logic [8:0] a,
                             input logic [3:0] be, input logic [31:0] wd);
        if (!wr) begin
            last_rd = ref_mem[a];
        end else begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[a][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    task automatic run_req(input logic wr, input logic [8:0] a,
                           input logic [3:0] be, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd,
                           output logic er, output int nen,
                           output int enk, output int wrk,
                           output logic [31:0] wdin, output int rlow);
        int k;
        int w;
        lat = 0; rd = '0; er = 1'b0; nen = 0;
        enk = 0; wrk = 0; wdin = '0; rlow = 0;
        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_be    = be;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (lat == 0 && k <= 10) begin
            if (rom_enable) begin
                nen++;
                if (enk == 0) enk = k;
            end
            if (rom_wren) begin
                wrk  = k;
                wdin = rom_dinp;
            end
            if (!req_ready) rlow++;
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_data;
                er  = rsp_err;
            end else begin
                @(negedge clk);
                k++;
            end
        end
    endtask

    initial begin
        int lat, nen, enk, wrk, rlow, k, nrsp;
        logic [31:0] rd, wdin, erd;
        logic er, rdy_at;
        int rk [2];
        logic [31:0] rdv [2];
        logic wr;
        logic [8:0] a;
        logic [3:0] be;
        logic [31:0] wd;
        logic [3:0] ro_bes [2];

        n_chk = 0; n_pass = 0; bad_wren = 0; bad_err = 0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_be = '0; req_wdata = '0;
        ro_valid = 1'b0; ro_write = 1'b0; ro_addr = '0;
        ro_be = '0; ro_wdata = '0; ro_dout = 32'h0BAD_F00D;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        last_rd = '0;

        tbl[0] = '{1'b0, 9'h000, 4'h0, 32'h0, 3, 32'h55AA0001, 1, 0, 32'h0};
        tbl[1] = '{1'b1, 9'h1FF, 4'hF, 32'hDEADBEEF, 2, 32'h55AA0001,
                   1, 1, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 9'h1FF, 4'h0, 32'h0, 3, 32'hDEADBEEF, 1, 0, 32'h0};
        tbl[3] = '{1'b1, 9'h010, 4'b0101, 32'hAABBCCDD, 4, 32'hDEADBEEF,
                   2, 3, 32'h11BB33DD};
        tbl[4] = '{1'b0, 9'h010, 4'h0, 32'h0, 3, 32'h11BB33DD, 1, 0, 32'h0};
        tbl[5] = '{1'b1, 9'h020, 4'h0, 32'hFFFFFFFF, 1, 32'h11BB33DD,
                   0, 0, 32'h0};
        tbl[6] = '{1'b0, 9'h020, 4'h0, 32'h0, 3, 32'h0020C0DE, 1, 0, 32'h0};

        // Preload the ROM model while reset is held.
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = 9'(i);
            pl_data = init_word(i);
            ref_mem[i] = init_word(i);
        end
        @(negedge clk);
        pl_we = 1'b0;

        check("rst_ready", {31'b0, req_ready}, 0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_rsp_err", {31'b0, rsp_err}, 0);
        check("rst_enable", {31'b0, rom_enable}, 0);
        check("rst_wren", {31'b0, rom_wren}, 0);
        check("rst_address", {23'b0, rom_address}, 0);
        check("rst_dinp", rom_dinp, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ro_ready", {31'b0, ro_ready}, 0);

        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'b0, req_ready}, 1);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            run_req(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wd,
                    lat, rd, er, nen, enk, wrk, wdin, rlow);
            check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_data", i), rd, tbl[i].rd);
            check($sformatf("vec%0d_err", i), {31'b0, er}, 0);
            check($sformatf("vec%0d_nen", i), nen, tbl[i].nen);
            check($sformatf("vec%0d_enk", i), enk, (tbl[i].nen > 0) ? 1 : 0);
            check($sformatf("vec%0d_wrk", i), wrk, tbl[i].wrk);
            check($sformatf("vec%0d_ready_low", i), rlow, tbl[i].lat - 1);
            if (tbl[i].wrk != 0)
                check($sformatf("vec%0d_dinp", i), wdin, tbl[i].wdin);
            ref_apply(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wd);
        end
        check("be0_rom_unchanged", rom[9'h020], 32'h0020C0DE);

        // Back-to-back reads with req_valid held throughout.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h001;
        @(negedge clk);
        k = 1;
        req_addr = 9'h002;
        check("b2b_ready_low", {31'b0, req_ready}, 0);
        nrsp = 0; rdy_at = 1'b0;
        rk[0] = 0; rk[1] = 0; rdv[0] = '0; rdv[1] = '0;
        while (k <= 12 && nrsp < 2) begin
            if (rsp_valid) begin
                rk[nrsp]  = k;
                rdv[nrsp] = rsp_data;
                if (nrsp == 0) rdy_at = req_ready;
                nrsp++;
            end
            if (k == 4) req_valid = 1'b0;
            @(negedge clk);
            k++;
        end
        req_valid = 1'b0;
        check("b2b_rsp1_cycle", rk[0], 3);
        check("b2b_rsp2_cycle", rk[1], 6);
        check("b2b_rsp1_data", rdv[0], ref_mem[1]);
        check("b2b_rsp2_data", rdv[1], ref_mem[2]);
        check("b2b_ready_in_rsp", {31'b0, rdy_at}, 1);
        last_rd = ref_mem[2];

        // Reset in the merge cycle of a partial write.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h030;
        req_be = 4'b0011; req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstw_read_en", {31'b0, rom_enable}, 1);
        check("rstw_read_wren", {31'b0, rom_wren}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw_ready_in_rst", {31'b0, req_ready}, 0);
        @(negedge clk);
        check("rstw_rsp_data", rsp_data, 0);
        check("rstw_address", {23'b0, rom_address}, 0);
        check("rstw_dinp", rom_dinp, 0);
        rst = 1'b0;
        #1;
        check("rstw_ready_after", {31'b0, req_ready}, 1);
        nen = 0; nrsp = 0;
        for (int i = 0; i < 4; i++) begin
            if (rom_enable || rom_wren) nen++;
            if (rsp_valid) nrsp++;
            @(negedge clk);
        end
        check("rstw_no_rom_access", nen, 0);
        check("rstw_no_rsp", nrsp, 0);
        check("rstw_word_kept", rom[9'h030], ref_mem[9'h030]);
        last_rd = '0;

        // Randomized traffic against the shadow memory.
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom);
            a  = (($urandom & 3) == 0) ? 9'($urandom)
                                       : 9'($urandom_range(0, 31));
            be = 4'($urandom);
            wd = $urandom;
            erd = wr ? last_rd : ref_mem[a];
            run_req(wr, a, be, wd, lat, rd, er, nen, enk, wrk, wdin, rlow);
            check("rnd_lat", lat, exp_lat(wr, be));
            check("rnd_data", rd, erd);
            check("rnd_err", {31'b0, er}, 0);
            check("rnd_nen", nen, exp_nen(wr, be));
            check("rnd_ready_low", rlow, exp_lat(wr, be) - 1);
            ref_apply(wr, a, be, wd);
        end

        // Read-only instance: writes are dropped with an error ack.
        ro_bes[0] = 4'hF;
        ro_bes[1] = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            check("ro_ready", {31'b0, ro_ready}, 1);
            ro_valid = 1'b1; ro_write = 1'b1; ro_addr = 9'h1FF;
            ro_be = ro_bes[i]; ro_wdata = 32'h1234_5678;
            @(negedge clk);
            ro_valid = 1'b0;
            check("ro_wr_ack", {31'b0, ro_rsp_valid}, 1);
            check("ro_wr_err", {31'b0, ro_rsp_err}, 1);
            check("ro_wr_no_en", {31'b0, ro_en}, 0);
            @(negedge clk);
            check("ro_wr_ack_pulse", {31'b0, ro_rsp_valid}, 0);
            check("ro_wr_no_en2", {31'b0, ro_en | ro_wren}, 0);
        end
        ro_valid = 1'b1; ro_write = 1'b0; ro_addr = 9'h003;
        @(negedge clk);
        ro_valid = 1'b0;
        check("ro_rd_en", {31'b0, ro_en}, 1);
        @(negedge clk);
        @(negedge clk);
        check("ro_rd_valid", {31'b0, ro_rsp_valid}, 1);
        check("ro_rd_data", ro_rsp_data, 32'h0BAD_F00D);
        check("ro_rd_err", {31'b0, ro_rsp_err}, 0);

        check("wren_without_enable", bad_wren, 0);
        check("err_without_valid", bad_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
